i2c_slave_controller: RTL and testbench

I2C target (responder) for the team's i2c_master_controller. Oversamples SCL/SDA on the system clock, detects START/STOP, and matches a fixed device address. Receives write bytes and transmits read bytes over an open-drain SDA. Presents a simple byte-level interface to local logic. SCL is input-only; the block does not stretch the clock.

---
 rtl/i2c_slave_controller.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_slave_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_controller.sv
// ---------------------------------------------------------------------------
// i2c_slave_controller
//
// I2C target that answers a single fixed device address. SCL and SDA are
// oversampled on clk through two-flop synchronizers plus a history flop, so
// every bus edge becomes a one-cycle strobe. START/STOP are recognised in any
// state. Write bytes are shifted in and ACKed; read bytes are fetched from
// tx_data and shifted out over an open-drain SDA. SCL is never stretched.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous reset, active-low
//   i2c_scl   bus clock from the master (input only)
//   i2c_sda   bus data, driven only to 0 or released (Z)
//   tx_data   byte to return on a read, sampled when tx_load pulses
//   rx_data   last byte received on a write
//   rx_valid  one-cycle pulse when rx_data updates
//   tx_load   one-cycle pulse when tx_data is sampled
//   rw_dir    R/W bit of the last matched address (1 = read)
//   busy      high from address match until STOP/START or a NACKed read
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_slave_controller #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h42
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_scl,
  inout  wire                   i2c_sda,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_load,
  output logic                  rw_dir,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, WAIT_STOP
  } state_t;

  state_t                state;
  logic                  scl_p0, scl_p1, scl_p2;
  logic                  sda_p0, sda_p1, sda_p2;
  logic                  sda_oe;
  logic [CNT_W-1:0]      cnt;
  logic                  done;
  logic [ADDR_WIDTH:0]   addr_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] tx_sr;

  // Open-drain output: only ever pull low or release.
  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  // Edge strobes from the synchronized level (p1) and its history (p2)
  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign sda_rise  = sda_p1 & ~sda_p2;
  assign sda_fall  = ~sda_p1 & sda_p2;
  assign start_det = sda_fall & scl_p1;
  assign stop_det  = sda_rise & scl_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_p0   <= 1'b1;
      scl_p1   <= 1'b1;
      scl_p2   <= 1'b1;
      sda_p0   <= 1'b1;
      sda_p1   <= 1'b1;
      sda_p2   <= 1'b1;
      state    <= IDLE;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      rw_dir   <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      // Synchronizer stages p0 -> p1 -> p2
      scl_p0   <= i2c_scl;
      scl_p1   <= scl_p0;
      scl_p2   <= scl_p1;
      sda_p0   <= i2c_sda;
      sda_p1   <= sda_p0;
      sda_p2   <= sda_p1;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;

      // Bus conditions win over any SCL edge seen in the same cycle.
      if (start_det) begin
        state  <= ADDR;
        cnt    <= ADDR_LAST;
        done   <= 1'b0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;

          ADDR: begin
            // ADDR_WIDTH address bits plus R/W: counter runs ADDR_WIDTH..0
            if (scl_rise) begin
              addr_sr <= {addr_sr[ADDR_WIDTH-1:0], sda_p1};
              if (cnt == '0) done <= 1'b1;
              else           cnt  <= cnt - 1'b1;
            end else if (scl_fall && done) begin
              if (addr_sr[ADDR_WIDTH:1] == SLAVE_ADDR) begin
                state  <= ADDR_ACK;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw_dir <= addr_sr[0];
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              cnt  <= DATA_LAST;
              done <= 1'b0;
              if (!rw_dir) begin
                sda_oe <= 1'b0;
                state  <= WRITE_DATA;
              end else begin
                tx_load <= 1'b1;
                tx_sr   <= tx_data;
                sda_oe  <= ~tx_data[DATA_WIDTH-1];
                state   <= READ_DATA;
              end
            end
          end

          WRITE_DATA: begin
            if (scl_rise) begin
              rx_sr <= {rx_sr[DATA_WIDTH-2:0], sda_p1};
              if (cnt == '0) done <= 1'b1;
              else           cnt  <= cnt - 1'b1;
            end else if (scl_fall && done) begin
              rx_data  <= rx_sr;
              rx_valid <= 1'b1;
              sda_oe   <= 1'b1;
              state    <= WRITE_ACK;
            end
          end

          WRITE_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              cnt    <= DATA_LAST;
              done   <= 1'b0;
              state  <= WRITE_DATA;
            end
          end

          READ_DATA: begin
            // MSB is already on the bus; cnt counts the bits still to send.
            if (scl_fall) begin
              if (cnt == '0) begin
                sda_oe <= 1'b0;
                done   <= 1'b0;
                state  <= READ_ACK;
              end else begin
                tx_sr  <= tx_sr << 1;
                sda_oe <= ~tx_sr[DATA_WIDTH-2];
                cnt    <= cnt - 1'b1;
              end
            end
          end

          READ_ACK: begin
            // done marks a master ACK seen on this clock's rising edge.
            if (scl_rise) begin
              if (!sda_p1) begin
                done <= 1'b1;
              end else begin
                state <= WAIT_STOP;
                busy  <= 1'b0;
              end
            end else if (scl_fall && done) begin
              tx_load <= 1'b1;
              tx_sr   <= tx_data;
              sda_oe  <= ~tx_data[DATA_WIDTH-1];
              cnt     <= DATA_LAST;
              done    <= 1'b0;
              state   <= READ_DATA;
            end
          end

          WAIT_STOP: sda_oe <= 1'b0;

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_controller.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_controller
//
// Directed bench acting as I2C master for i2c_slave_controller. A monitor
// counts rx_valid / tx_load pulses, cycles where the slave pulls SDA low, and
// cycles where both pulses coincide.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_controller;

  localparam int Q = 10;  // clk cycles per quarter of an SCL bit

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_load, rw_dir, busy;
  wire        sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_controller dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_scl  (scl),
    .i2c_sda  (sda),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_load  (tx_load),
    .rw_dir   (rw_dir),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int rv_cnt = 0;
  int tl_cnt = 0;
  int slave_low_cnt = 0;
  int overlap_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid) rv_cnt++;
    if (tx_load) tl_cnt++;
    if (rx_valid && tx_load) overlap_cnt++;
    if (rst && sda === 1'b0 && !m_low) slave_low_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bus primitives; every one leaves SCL low except stop().
  task automatic i2c_start();
    m_low = 1'b1; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b1; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b0; tick(Q);
  endtask

  task automatic mbit(input logic b, output logic rd);
    m_low = ~b; tick(Q);
    scl = 1'b1; tick(Q);
    rd = sda;
    scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic rd;
    for (int i = 7; i >= 0; i--) mbit(b[i], rd);
    mbit(1'b1, ack);
  endtask

  task automatic recv8(output logic [7:0] d);
    logic rd;
    for (int i = 7; i >= 0; i--) begin
      mbit(1'b1, rd);
      d[i] = rd;
    end
  endtask

  initial begin
    logic       ack, rd;
    logic [7:0] d;
    int         rv0, tl0;

    // Reset state
    rst = 1'b0;
    tick(3);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_tx_load", tx_load, 1'b0);
    chk("reset_rw_dir", rw_dir, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_sda", sda, 1'b1);
    rst = 1'b1;
    tick(5);

    // Single-byte write of 0xA5 to 0x42
    rv0 = rv_cnt;
    slave_low_cnt = 0;
    i2c_start();
    send_byte(8'h84, ack);
    chk("wr_addr_ack", ack, 1'b0);
    chk("wr_busy", busy, 1'b1);
    chk("wr_rw_dir", rw_dir, 1'b0);
    send_byte(8'hA5, ack);
    chk("wr_data_ack", ack, 1'b0);
    chk("wr_rx_data", rx_data, 8'hA5);
    i2c_stop();
    chk("wr_busy_after_stop", busy, 1'b0);
    chk("wr_rx_valid_pulses", rv_cnt - rv0, 1);
    chk("wr_slave_drove_low", slave_low_cnt > 0, 1'b1);

    // Address mismatch: 0x43 + W
    rv0 = rv_cnt;
    slave_low_cnt = 0;
    i2c_start();
    send_byte(8'h86, ack);
    chk("mm_addr_nack", ack, 1'b1);
    chk("mm_busy", busy, 1'b0);
    send_byte(8'hFF, ack);
    chk("mm_data_nack", ack, 1'b1);
    i2c_stop();
    chk("mm_sda_never_low", slave_low_cnt, 0);
    chk("mm_no_rx_valid", rv_cnt - rv0, 0);
    chk("mm_rx_data_kept", rx_data, 8'hA5);

    // Two-byte read: 0x3C then 0xC3
    tl0 = tl_cnt;
    tx_data = 8'h3C;
    i2c_start();
    send_byte(8'h85, ack);
    chk("rd_addr_ack", ack, 1'b0);
    chk("rd_rw_dir", rw_dir, 1'b1);
    recv8(d);
    chk("rd_byte0", d, 8'h3C);
    tx_data = 8'hC3;
    mbit(1'b0, rd);
    chk("rd_busy_mid", busy, 1'b1);
    recv8(d);
    chk("rd_byte1", d, 8'hC3);
    mbit(1'b1, rd);
    chk("rd_busy_after_nack", busy, 1'b0);
    chk("rd_tx_load_pulses", tl_cnt - tl0, 2);
    chk("rd_sda_released", sda, 1'b1);
    i2c_stop();
    chk("rd_busy_after_stop", busy, 1'b0);

    // Write 0x11, repeated START, read 0x5A
    i2c_start();
    send_byte(8'h84, ack);
    chk("rs_wr_addr_ack", ack, 1'b0);
    send_byte(8'h11, ack);
    chk("rs_wr_data_ack", ack, 1'b0);
    chk("rs_rx_data", rx_data, 8'h11);
    chk("rs_rw_dir_wr", rw_dir, 1'b0);
    tx_data = 8'h5A;
    i2c_rstart();
    chk("rs_busy_after_rstart", busy, 1'b0);
    send_byte(8'h85, ack);
    chk("rs_rd_addr_ack", ack, 1'b0);
    chk("rs_rw_dir_rd", rw_dir, 1'b1);
    recv8(d);
    chk("rs_rd_byte", d, 8'h5A);
    mbit(1'b1, rd);
    i2c_stop();
    chk("rs_rx_data_kept", rx_data, 8'h11);

    // STOP in the middle of a write byte, then a full write of 0x77
    rv0 = rv_cnt;
    i2c_start();
    send_byte(8'h84, ack);
    chk("mid_addr_ack", ack, 1'b0);
    mbit(1'b1, rd);
    mbit(1'b0, rd);
    mbit(1'b1, rd);
    mbit(1'b0, rd);
    i2c_stop();
    chk("mid_no_rx_valid", rv_cnt - rv0, 0);
    chk("mid_sda_released", sda, 1'b1);
    chk("mid_busy", busy, 1'b0);
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h77, ack);
    chk("mid_next_ack", ack, 1'b0);
    i2c_stop();
    chk("mid_next_rx_data", rx_data, 8'h77);
    chk("mid_next_rx_valid", rv_cnt - rv0, 1);

    // Reset while the slave drives a 0 data bit
    tx_data = 8'h00;
    i2c_start();
    send_byte(8'h85, ack);
    chk("rst_addr_ack", ack, 1'b0);
    chk("rst_sda_driven", sda, 1'b0);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    chk("rst_sda_released", sda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rw_dir", rw_dir, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_load", tx_load, 1'b0);
    tick(2);
    i2c_stop();
    i2c_start();
    send_byte(8'h84, ack);
    chk("rst_next_addr_ack", ack, 1'b0);
    send_byte(8'h9C, ack);
    chk("rst_next_data_ack", ack, 1'b0);
    i2c_stop();
    chk("rst_next_rx_data", rx_data, 8'h9C);

    chk("no_rx_tx_overlap", overlap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
